// File: rtl/keypad_scan_driver.sv
// keypad_scan_driver: strobes 4x4 keypad columns, debounces over whole scans, and reports press/release events.
module keypad_scan_driver #(
    parameter int SCAN_TICKS     = 100000,
    parameter int SETTLE_TICKS   = 8,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_up,
    output logic       key_down
);
    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    // nibble {col,row} holds the key printed at that crossing
    localparam logic [63:0] KEYMAP = 64'hDCBA_E963_F852_0741;

    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} state_t;

    function automatic logic [3:0] key_at(input logic [1:0] c, input logic [1:0] r);
        return KEYMAP[{c, r}*4 +: 4];
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  row_m_q, row_s_q;
    logic [1:0]  phase_q, phase_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]  hits_q, hits_d, hits_s;
    logic [3:0]  cand_q, cand_d, cand_s;
    logic        seen_q, seen_d, seen_s;
    logic [3:0]  pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d, key_up_q, key_up_d, key_down_q, key_down_d;
    logic        sample, scan_end, wrap;

    assign sample   = tick_q == TW'(SETTLE_TICKS);
    assign scan_end = sample && phase_q == 2'd3;
    assign wrap     = tick_q == TW'(SCAN_TICKS - 1);
    assign tick_d   = wrap ? '0 : tick_q + 1'b1;
    assign phase_d  = wrap ? phase_q + 2'd1 : phase_q;
    assign cnt_inc  = cnt_q + 1'b1;
    assign col      = rst_n ? ~(4'b1000 >> phase_q) : 4'b1111;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_up    = key_up_q;
    assign key_down  = key_down_q;

    // fold this column's sample into the running scan accumulators
    always_comb begin
        hits_s = hits_q;
        cand_s = cand_q;
        seen_s = seen_q;
        for (int r = 0; r < 4; r++) begin
            if (!row_s_q[3-r]) begin
                if (hits_s == 2'd0) cand_s = key_at(phase_q, 2'(r));
                if (hits_s != 2'd2) hits_s = hits_s + 2'd1;
                if (key_at(phase_q, 2'(r)) == key_code_q) seen_s = 1'b1;
            end
        end
    end

    assign hits_d = !sample ? hits_q : scan_end ? 2'd0 : hits_s;
    assign cand_d = !sample ? cand_q : scan_end ? 4'd0 : cand_s;
    assign seen_d = !sample ? seen_q : scan_end ? 1'b0 : seen_s;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_up_d    = 1'b0;
        key_down_d  = key_down_q;
        if (scan_end) begin
            case (state_q)
                IDLE: if (hits_s == 2'd1) begin
                    pend_d  = cand_s;
                    cnt_d   = CW'(1);
                    state_d = PRESS_PEND;
                end
                PRESS_PEND: if (hits_s != 2'd1) begin
                    state_d = IDLE;
                end else if (cand_s != pend_q) begin
                    pend_d = cand_s;
                    cnt_d  = CW'(1);
                end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                    key_code_d  = pend_q;
                    key_valid_d = 1'b1;
                    key_down_d  = 1'b1;
                    state_d     = HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
                HELD: if (!seen_s) begin
                    cnt_d   = CW'(1);
                    state_d = REL_PEND;
                end
                REL_PEND: if (seen_s) begin
                    state_d = HELD;
                end else if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                    key_up_d   = 1'b1;
                    key_down_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_m_q     <= 4'b1111;
            row_s_q     <= 4'b1111;
            phase_q     <= 2'd0;
            tick_q      <= '0;
            hits_q      <= 2'd0;
            cand_q      <= 4'd0;
            seen_q      <= 1'b0;
            pend_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_up_q    <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_m_q     <= row;
            row_s_q     <= row_m_q;
            phase_q     <= phase_d;
            tick_q      <= tick_d;
            hits_q      <= hits_d;
            cand_q      <= cand_d;
            seen_q      <= seen_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_up_q    <= key_up_d;
            key_down_q  <= key_down_d;
        end
    end
endmodule
